// File: rtl/decode_stage_hz.sv
// decode_stage_hz: MIPS instruction-decode stage with hazard detection.
//
// Purpose:
//   Register file with writeback port, main control decode, sign extension
//   and the ID/EX pipeline register. A load-use hazard raises the
//   combinational stall output and loads a control bubble into ID/EX. The
//   flush input (taken branch) also loads a bubble.
//
// Build option:
//   DECODE_BYPASS_EN - when defined, a writeback to a register being read in
//                      the same cycle is forwarded straight to the read port.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   wb_reg_write                writeback enable
//   wb_write_reg_location       writeback register index
//   mem_wb_write_data           writeback data
//   if_id_instr, if_id_npc      instruction and next PC from IF/ID
//   flush                       squash the instruction being decoded
//   id_ex_wb                    {RegWrite, MemToReg}
//   id_ex_mem                   {Branch, MemRead, MemWrite}
//   id_ex_execute               {RegDst, ALUOp[1:0], ALUSrc}
//   id_ex_npc, id_ex_readdat1,
//   id_ex_readdat2,
//   id_ex_sign_ext              registered datapath values
//   id_ex_instr_bits_20_16/15_11 registered rt / rd
//   stall                       hold PC and IF/ID when high

module decode_stage_hz #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RF_DEPTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_write_reg_location,
   input  logic [DATA_W-1:0] mem_wb_write_data,
   input  logic [31:0]       if_id_instr,
   input  logic [DATA_W-1:0] if_id_npc,
   input  logic              flush,
   output logic [1:0]        id_ex_wb,
   output logic [2:0]        id_ex_mem,
   output logic [3:0]        id_ex_execute,
   output logic [DATA_W-1:0] id_ex_npc,
   output logic [DATA_W-1:0] id_ex_readdat1,
   output logic [DATA_W-1:0] id_ex_readdat2,
   output logic [DATA_W-1:0] id_ex_sign_ext,
   output logic [4:0]        id_ex_instr_bits_20_16,
   output logic [4:0]        id_ex_instr_bits_15_11,
   output logic              stall
);

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;

   logic [5:0] opcode;
   logic [4:0] rs, rt, rd;

   assign opcode = if_id_instr[31:26];
   assign rs     = if_id_instr[25:21];
   assign rt     = if_id_instr[20:16];
   assign rd     = if_id_instr[15:11];

   // Register 0 is hard-wired to zero, so storage starts at index 1.
   logic [DATA_W-1:0] rf_q [1:RF_DEPTH-1];
   logic [DATA_W-1:0] rf_d [1:RF_DEPTH-1];

   logic [1:0]        id_ex_wb_q, id_ex_wb_d;
   logic [2:0]        id_ex_mem_q, id_ex_mem_d;
   logic [3:0]        id_ex_ex_q, id_ex_ex_d;
   logic [DATA_W-1:0] id_ex_npc_q, id_ex_npc_d;
   logic [DATA_W-1:0] id_ex_rd1_q, id_ex_rd1_d;
   logic [DATA_W-1:0] id_ex_rd2_q, id_ex_rd2_d;
   logic [DATA_W-1:0] id_ex_sext_q, id_ex_sext_d;
   logic [4:0]        id_ex_rt_q, id_ex_rt_d;
   logic [4:0]        id_ex_rd_q, id_ex_rd_d;

   logic [1:0]        ctl_wb;
   logic [2:0]        ctl_mem;
   logic [3:0]        ctl_ex;
   logic [DATA_W-1:0] read1, read2, sext;
   logic              wb_write_en;
   logic              bubble;

   // Writes to $0 or beyond the implemented depth are dropped.
   assign wb_write_en = wb_reg_write && (wb_write_reg_location != 5'd0) &&
                        (32'(wb_write_reg_location) < RF_DEPTH);

   // Main control decode.
   always_comb begin
      ctl_wb  = 2'b00;
      ctl_mem = 3'b000;
      ctl_ex  = 4'b0000;
      case (opcode)
         OpRtype: begin
            ctl_wb = 2'b10; ctl_mem = 3'b000; ctl_ex = 4'b1100;
         end
         OpLw: begin
            ctl_wb = 2'b11; ctl_mem = 3'b010; ctl_ex = 4'b0001;
         end
         OpSw: begin
            ctl_wb = 2'b00; ctl_mem = 3'b001; ctl_ex = 4'b0001;
         end
         OpBeq: begin
            ctl_wb = 2'b00; ctl_mem = 3'b100; ctl_ex = 4'b0010;
         end
         default: begin
            ctl_wb = 2'b00; ctl_mem = 3'b000; ctl_ex = 4'b0000;
         end
      endcase
   end

   assign sext = DATA_W'($signed(if_id_instr[15:0]));

   // Read ports: unmatched indices ($0 and out-of-range) fall through to 0.
   always_comb begin
      read1 = '0;
      read2 = '0;
      for (int i = 1; i < int'(RF_DEPTH); i++) begin
         if (rs == 5'(i)) read1 = rf_q[i];
         if (rt == 5'(i)) read2 = rf_q[i];
      end
`ifdef DECODE_BYPASS_EN
      // wb_write_en already excludes $0 and out-of-range targets.
      if (wb_write_en && (wb_write_reg_location == rs)) read1 = mem_wb_write_data;
      if (wb_write_en && (wb_write_reg_location == rt)) read2 = mem_wb_write_data;
`endif
   end

   always_comb begin
      for (int i = 1; i < int'(RF_DEPTH); i++) begin
         rf_d[i] = rf_q[i];
         if (wb_write_en && (wb_write_reg_location == 5'(i))) rf_d[i] = mem_wb_write_data;
      end
   end

   // Load-use: the load in ID/EX targets a register this instruction reads.
   assign stall = id_ex_mem_q[1] && (id_ex_rt_q != 5'd0) &&
                  ((id_ex_rt_q == rs) || (id_ex_rt_q == rt));

   assign bubble = stall || flush;

   // Bubbles zero only the control fields; the datapath still loads.
   always_comb begin
      id_ex_wb_d   = bubble ? 2'b00  : ctl_wb;
      id_ex_mem_d  = bubble ? 3'b000 : ctl_mem;
      id_ex_ex_d   = bubble ? 4'b0000 : ctl_ex;
      id_ex_npc_d  = if_id_npc;
      id_ex_rd1_d  = read1;
      id_ex_rd2_d  = read2;
      id_ex_sext_d = sext;
      id_ex_rt_d   = rt;
      id_ex_rd_d   = rd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < int'(RF_DEPTH); i++) rf_q[i] <= '0;
         id_ex_wb_q   <= '0;
         id_ex_mem_q  <= '0;
         id_ex_ex_q   <= '0;
         id_ex_npc_q  <= '0;
         id_ex_rd1_q  <= '0;
         id_ex_rd2_q  <= '0;
         id_ex_sext_q <= '0;
         id_ex_rt_q   <= '0;
         id_ex_rd_q   <= '0;
      end else begin
         for (int i = 1; i < int'(RF_DEPTH); i++) rf_q[i] <= rf_d[i];
         id_ex_wb_q   <= id_ex_wb_d;
         id_ex_mem_q  <= id_ex_mem_d;
         id_ex_ex_q   <= id_ex_ex_d;
         id_ex_npc_q  <= id_ex_npc_d;
         id_ex_rd1_q  <= id_ex_rd1_d;
         id_ex_rd2_q  <= id_ex_rd2_d;
         id_ex_sext_q <= id_ex_sext_d;
         id_ex_rt_q   <= id_ex_rt_d;
         id_ex_rd_q   <= id_ex_rd_d;
      end
   end

   assign id_ex_wb               = id_ex_wb_q;
   assign id_ex_mem              = id_ex_mem_q;
   assign id_ex_execute          = id_ex_ex_q;
   assign id_ex_npc              = id_ex_npc_q;
   assign id_ex_readdat1         = id_ex_rd1_q;
   assign id_ex_readdat2         = id_ex_rd2_q;
   assign id_ex_sign_ext         = id_ex_sext_q;
   assign id_ex_instr_bits_20_16 = id_ex_rt_q;
   assign id_ex_instr_bits_15_11 = id_ex_rd_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
module tb_decode_stage_hz;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_reg_write;
   logic [4:0]  wb_loc;
   logic [31:0] wb_data;
   logic [31:0] instr;
   logic [31:0] npc;
   logic        flush;

   // Default-parameter instance.
   logic [1:0]  wb;
   logic [2:0]  mem;
   logic [3:0]  ex;
   logic [31:0] o_npc, rd1, rd2, sx;
   logic [4:0]  rt, rd;
   logic        stall;

   // DATA_W=16, RF_DEPTH=8 instance.
   logic [1:0]  s_wb;
   logic [2:0]  s_mem;
   logic [3:0]  s_ex;
   logic [15:0] s_npc, s_rd1, s_rd2, s_sx;
   logic [4:0]  s_rt, s_rd;
   logic        s_stall;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decode_stage_hz dut (
      .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write),
      .wb_write_reg_location(wb_loc), .mem_wb_write_data(wb_data),
      .if_id_instr(instr), .if_id_npc(npc), .flush(flush),
      .id_ex_wb(wb), .id_ex_mem(mem), .id_ex_execute(ex), .id_ex_npc(o_npc),
      .id_ex_readdat1(rd1), .id_ex_readdat2(rd2), .id_ex_sign_ext(sx),
      .id_ex_instr_bits_20_16(rt), .id_ex_instr_bits_15_11(rd), .stall(stall)
   );

   decode_stage_hz #(.DATA_W(16), .RF_DEPTH(8)) dut_s (
      .clk(clk), .rst(rst), .wb_reg_write(wb_reg_write),
      .wb_write_reg_location(wb_loc), .mem_wb_write_data(wb_data[15:0]),
      .if_id_instr(instr), .if_id_npc(npc[15:0]), .flush(flush),
      .id_ex_wb(s_wb), .id_ex_mem(s_mem), .id_ex_execute(s_ex), .id_ex_npc(s_npc),
      .id_ex_readdat1(s_rd1), .id_ex_readdat2(s_rd2), .id_ex_sign_ext(s_sx),
      .id_ex_instr_bits_20_16(s_rt), .id_ex_instr_bits_15_11(s_rd), .stall(s_stall)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] npc;
      logic [1:0]  wb;
      logic [2:0]  mem;
      logic [3:0]  ex;
      logic [31:0] sx;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string name, input logic [1:0] ewb, input logic [2:0] emem,
                          input logic [3:0] eex);
      chk({name, ".wb"}, 32'(wb), 32'(ewb));
      chk({name, ".mem"}, 32'(mem), 32'(emem));
      chk({name, ".ex"}, 32'(ex), 32'(eex));
   endtask

   localparam logic [31:0] Add222 = 32'h00421020;  // add $2,$2,$2
   localparam logic [31:0] Nop3f  = 32'hFC000000;
   localparam logic [31:0] Lw2    = 32'h8C820002;  // lw $2,2($4)

   initial begin
      vecs[0] = '{32'h00A41020, 32'd1, 2'b10, 3'b000, 4'b1100, 32'h00001020, 5'd4, 5'd2};
      vecs[1] = '{32'h10000008, 32'd2, 2'b00, 3'b100, 4'b0010, 32'h00000008, 5'd0, 5'd0};
      vecs[2] = '{32'h1000FFFC, 32'd3, 2'b00, 3'b100, 4'b0010, 32'hFFFFFFFC, 5'd0, 5'd31};
      vecs[3] = '{32'hAC820002, 32'd4, 2'b00, 3'b001, 4'b0001, 32'h00000002, 5'd2, 5'd0};
      vecs[4] = '{32'hFC000000, 32'd5, 2'b00, 3'b000, 4'b0000, 32'h00000000, 5'd0, 5'd0};
      vecs[5] = '{32'h8C820002, 32'd6, 2'b11, 3'b010, 4'b0001, 32'h00000002, 5'd2, 5'd0};

      rst = 1'b1; wb_reg_write = 1'b0; wb_loc = '0; wb_data = '0;
      instr = 32'h00A41020; npc = 32'd1; flush = 1'b0;

      // Reset state.
      #12;
      chk("rst.wb", 32'(wb), 32'd0);
      chk("rst.mem", 32'(mem), 32'd0);
      chk("rst.ex", 32'(ex), 32'd0);
      chk("rst.npc", o_npc, 32'd0);
      chk("rst.rt", 32'(rt), 32'd0);
      chk("rst.stall", 32'(stall), 32'd0);
      step();
      rst = 1'b0;

      // Decode sweep; first row is the first edge after reset release.
      for (int i = 0; i < 6; i++) begin
         instr = vecs[i].instr;
         npc   = vecs[i].npc;
         step();
         chk_ctl($sformatf("vec%0d", i), vecs[i].wb, vecs[i].mem, vecs[i].ex);
         chk($sformatf("vec%0d.sx", i), sx, vecs[i].sx);
         chk($sformatf("vec%0d.rt", i), 32'(rt), 32'(vecs[i].rt));
         chk($sformatf("vec%0d.rd", i), 32'(rd), 32'(vecs[i].rd));
         chk($sformatf("vec%0d.npc", i), o_npc, vecs[i].npc);
         chk($sformatf("vec%0d.rd1", i), rd1, 32'd0);
      end

      // Load-use: LW $2 now in ID/EX, ADD reads $2.
      instr = Add222;
      #1;
      chk("lu.stall", 32'(stall), 32'd1);
      chk("lu.s_stall", 32'(s_stall), 32'd1);
      step();
      chk_ctl("lu.bubble", 2'b00, 3'b000, 4'b0000);
      chk("lu.stall_clear", 32'(stall), 32'd0);
      step();
      chk_ctl("lu.add", 2'b10, 3'b000, 4'b1100);

      // Writeback then read.
      instr = Nop3f;
      wb_reg_write = 1'b1; wb_loc = 5'd2; wb_data = 32'd100;
      step();
      wb_loc = 5'd9; wb_data = 32'h77;
      step();
      wb_loc = 5'd0; wb_data = 32'h33;
      step();
      wb_reg_write = 1'b0;
      instr = Add222;
      step();
      chk("wr.rd1", rd1, 32'd100);
      chk("wr.rd2", rd2, 32'd100);
      chk("wr.s_rd1", 32'(s_rd1), 32'd100);
      instr = 32'h00090020;  // add $0,$0,$9
      step();
      chk("wr.r0", rd1, 32'd0);
      chk("wr.r9", rd2, 32'h77);
      chk("wr.s_r0", 32'(s_rd1), 32'd0);
      chk("wr.s_r9", 32'(s_rd2), 32'd0);

      // Same-cycle writeback to a register being read.
      instr = Add222;
      wb_reg_write = 1'b1; wb_loc = 5'd2; wb_data = 32'h55;
      step();
`ifdef DECODE_BYPASS_EN
      chk("byp.rd1", rd1, 32'h55);
      chk("byp.s_rd1", 32'(s_rd1), 32'h55);
`else
      chk("byp.rd1", rd1, 32'd100);
      chk("byp.s_rd1", 32'(s_rd1), 32'd100);
`endif
      wb_reg_write = 1'b0;
      step();
      chk("byp.next", rd1, 32'h55);

      // LW with rt=0 followed by a reader of $0: no hazard.
      instr = 32'h8C800002;
      step();
      instr = 32'h00001020;
      #1;
      chk("lu0.stall", 32'(stall), 32'd0);
      step();
      chk_ctl("lu0.add", 2'b10, 3'b000, 4'b1100);

      // Flush alone.
      instr = Add222; flush = 1'b1;
      step();
      chk_ctl("fl", 2'b00, 3'b000, 4'b0000);
      chk("fl.rd1", rd1, 32'h55);
      chk("fl.rt", 32'(rt), 32'd2);

      // Flush together with stall.
      flush = 1'b0; instr = Lw2;
      step();
      instr = Add222; flush = 1'b1;
      #1;
      chk("flst.stall", 32'(stall), 32'd1);
      step();
      chk_ctl("flst", 2'b00, 3'b000, 4'b0000);

      // Asynchronous reset during a stall.
      flush = 1'b0; instr = Lw2;
      step();
      instr = Add222;
      #1;
      chk("rs.stall_pre", 32'(stall), 32'd1);
      rst = 1'b1;
      #1;
      chk_ctl("rs", 2'b00, 3'b000, 4'b0000);
      chk("rs.rd1", rd1, 32'd0);
      chk("rs.npc", o_npc, 32'd0);
      chk("rs.stall", 32'(stall), 32'd0);
      #1;
      rst = 1'b0;
      step();
      chk_ctl("rs.add", 2'b10, 3'b000, 4'b1100);
      chk("rs.reg_cleared", rd1, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
